// File: rtl/ccp_rdrsp_tx.sv
// CCP read-response transmitter: queues per-op response commands and emits
// burst_len+1 registered beats sourced from the array read path, bypass data or a cancel beat.
module ccp_rdrsp_tx #(
    parameter int DATA_W      = 128,
    parameter int BYTE_EN_W   = 16,
    parameter int BURST_LEN_W = 2,
    parameter int CMD_DEPTH   = 4,
    parameter int BYP_DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [BURST_LEN_W-1:0] cmd_burst_len,
    input  logic                   cmd_bypass,
    input  logic                   cmd_cancel,
    input  logic                   arr_valid,
    input  logic [DATA_W-1:0]      arr_data,
    output logic                   arr_ready,
    input  logic                   byp_valid,
    input  logic [DATA_W-1:0]      byp_data,
    input  logic [BYTE_EN_W-1:0]   byp_byteen,
    input  logic                   byp_last,
    output logic                   byp_ready,
    output logic                   cache_rdrsp_valid,
    output logic [DATA_W-1:0]      cache_rdrsp_data,
    output logic [BYTE_EN_W-1:0]   cache_rdrsp_byteen,
    output logic                   cache_rdrsp_last,
    output logic                   cache_rdrsp_cancel,
    input  logic                   ctrl_rdrsp_ready,
    output logic                   err_last_mismatch
);
    localparam int CMD_W  = BURST_LEN_W + 2;
    localparam int BYP_W  = DATA_W + BYTE_EN_W + 1;
    localparam int CMD_AW = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
    localparam int CMD_CW = $clog2(CMD_DEPTH + 1);
    localparam int BYP_AW = (BYP_DEPTH > 1) ? $clog2(BYP_DEPTH) : 1;
    localparam int BYP_CW = $clog2(BYP_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, ARRAY, BYPASS, CANCEL} state_t;

    // ---------------- command FIFO: {burst_len, bypass, cancel}
    logic [CMD_W-1:0]  cmd_mem [CMD_DEPTH];
    logic [CMD_AW-1:0] cmd_wr_ptr_reg, cmd_rd_ptr_reg;
    logic [CMD_CW-1:0] cmd_count_reg;
    logic              cmd_full, cmd_not_empty, cmd_push, cmd_pop;
    logic [CMD_W-1:0]  cmd_head;

    assign cmd_full      = (cmd_count_reg == CMD_CW'(CMD_DEPTH));
    assign cmd_not_empty = (cmd_count_reg != '0);
    assign cmd_ready     = !cmd_full;
    assign cmd_push      = cmd_valid && !cmd_full;
    assign cmd_head      = cmd_mem[cmd_rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (cmd_push) begin
            cmd_mem[cmd_wr_ptr_reg] <= {cmd_burst_len, cmd_bypass, cmd_cancel};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_wr_ptr_reg <= '0;
            cmd_rd_ptr_reg <= '0;
            cmd_count_reg  <= '0;
        end else begin
            if (cmd_push) begin
                cmd_wr_ptr_reg <= (cmd_wr_ptr_reg == CMD_AW'(CMD_DEPTH - 1)) ? '0 : cmd_wr_ptr_reg + 1'b1;
            end
            if (cmd_pop) begin
                cmd_rd_ptr_reg <= (cmd_rd_ptr_reg == CMD_AW'(CMD_DEPTH - 1)) ? '0 : cmd_rd_ptr_reg + 1'b1;
            end
            cmd_count_reg <= cmd_count_reg + CMD_CW'(cmd_push) - CMD_CW'(cmd_pop);
        end
    end

    // ---------------- bypass data FIFO: {data, byteen, last}
    logic [BYP_W-1:0]  byp_mem [BYP_DEPTH];
    logic [BYP_AW-1:0] byp_wr_ptr_reg, byp_rd_ptr_reg;
    logic [BYP_CW-1:0] byp_count_reg;
    logic              byp_full, byp_not_empty, byp_push, byp_pop;
    logic [BYP_W-1:0]  byp_head;

    assign byp_full      = (byp_count_reg == BYP_CW'(BYP_DEPTH));
    assign byp_not_empty = (byp_count_reg != '0);
    assign byp_ready     = !byp_full;
    assign byp_push      = byp_valid && !byp_full;
    assign byp_head      = byp_mem[byp_rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (byp_push) begin
            byp_mem[byp_wr_ptr_reg] <= {byp_data, byp_byteen, byp_last};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            byp_wr_ptr_reg <= '0;
            byp_rd_ptr_reg <= '0;
            byp_count_reg  <= '0;
        end else begin
            if (byp_push) begin
                byp_wr_ptr_reg <= (byp_wr_ptr_reg == BYP_AW'(BYP_DEPTH - 1)) ? '0 : byp_wr_ptr_reg + 1'b1;
            end
            if (byp_pop) begin
                byp_rd_ptr_reg <= (byp_rd_ptr_reg == BYP_AW'(BYP_DEPTH - 1)) ? '0 : byp_rd_ptr_reg + 1'b1;
            end
            byp_count_reg <= byp_count_reg + BYP_CW'(byp_push) - BYP_CW'(byp_pop);
        end
    end

    // ---------------- burst sequencer
    state_t                 state_reg, state_next;
    logic [BURST_LEN_W-1:0] beat_cnt_reg, beat_cnt_next;
    logic [BURST_LEN_W-1:0] burst_len_reg, burst_len_next;
    logic                   load_en, cnt_last, beat_load, err_set;
    logic [DATA_W-1:0]      beat_data;
    logic [BYTE_EN_W-1:0]   beat_byteen;
    logic                   beat_last, beat_cancel;

    logic                   valid_reg, last_reg, cancel_reg, err_reg;
    logic [DATA_W-1:0]      data_reg;
    logic [BYTE_EN_W-1:0]   byteen_reg;

    assign load_en  = !valid_reg || ctrl_rdrsp_ready;
    assign cnt_last = (beat_cnt_reg == burst_len_reg);

    always_comb begin
        state_next     = state_reg;
        beat_cnt_next  = beat_cnt_reg;
        burst_len_next = burst_len_reg;
        cmd_pop        = 1'b0;
        byp_pop        = 1'b0;
        arr_ready      = 1'b0;
        beat_load      = 1'b0;
        beat_data      = '0;
        beat_byteen    = '0;
        beat_last      = 1'b0;
        beat_cancel    = 1'b0;
        err_set        = 1'b0;

        case (state_reg)
            IDLE: begin
                cmd_pop = cmd_not_empty;
            end
            ARRAY: begin
                arr_ready = load_en;
                if (arr_valid && load_en) begin
                    beat_load   = 1'b1;
                    beat_data   = arr_data;
                    beat_byteen = '1;
                    beat_last   = cnt_last;
                end
            end
            BYPASS: begin
                if (load_en && byp_not_empty) begin
                    beat_load   = 1'b1;
                    byp_pop     = 1'b1;
                    beat_data   = byp_head[BYP_W-1 -: DATA_W];
                    beat_byteen = byp_head[BYTE_EN_W:1];
                    beat_last   = cnt_last;
                    err_set     = (byp_head[0] != cnt_last);
                end
            end
            CANCEL: begin
                if (load_en) begin
                    beat_load   = 1'b1;
                    beat_last   = 1'b1;
                    beat_cancel = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        if (beat_load) begin
            if (beat_last) begin
                beat_cnt_next = '0;
                state_next    = IDLE;
                cmd_pop       = cmd_not_empty;
            end else begin
                beat_cnt_next = beat_cnt_reg + 1'b1;
            end
        end

        // Popping the head starts its burst immediately, so back-to-back bursts have no bubble.
        if (cmd_pop) begin
            burst_len_next = cmd_head[CMD_W-1:2];
            beat_cnt_next  = '0;
            if (cmd_head[0]) begin
                state_next = CANCEL;
            end else if (cmd_head[1]) begin
                state_next = BYPASS;
            end else begin
                state_next = ARRAY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            beat_cnt_reg  <= '0;
            burst_len_reg <= '0;
        end else begin
            state_reg     <= state_next;
            beat_cnt_reg  <= beat_cnt_next;
            burst_len_reg <= burst_len_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_reg  <= 1'b0;
            data_reg   <= '0;
            byteen_reg <= '0;
            last_reg   <= 1'b0;
            cancel_reg <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            if (load_en) begin
                valid_reg <= beat_load;
                if (beat_load) begin
                    data_reg   <= beat_data;
                    byteen_reg <= beat_byteen;
                    last_reg   <= beat_last;
                    cancel_reg <= beat_cancel;
                end
            end
            if (err_set) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign cache_rdrsp_valid  = valid_reg;
    assign cache_rdrsp_data   = data_reg;
    assign cache_rdrsp_byteen = byteen_reg;
    assign cache_rdrsp_last   = last_reg;
    assign cache_rdrsp_cancel = cancel_reg;
    assign err_last_mismatch  = err_reg;

endmodule

// File: tb/tb_ccp_rdrsp_tx.sv
// Scoreboard bench for ccp_rdrsp_tx: sources feed cmd/array/bypass queues, a monitor
// compares each accepted beat against the expected-beat queue.
module tb_ccp_rdrsp_tx;
    localparam int DW = 128;
    localparam int BW = 16;
    localparam int LW = 2;

    typedef struct {
        logic [DW-1:0] data;
        logic [BW-1:0] be;
        logic          last;
        logic          cancel;
    } beat_t;
    typedef struct {
        logic [LW-1:0] len;
        logic          bypass;
        logic          cancel;
    } cmd_t;
    typedef struct {
        logic [DW-1:0] data;
        logic [BW-1:0] be;
        logic          last;
    } byp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready, cmd_bypass, cmd_cancel;
    logic [LW-1:0] cmd_burst_len;
    logic          arr_valid, arr_ready;
    logic [DW-1:0] arr_data;
    logic          byp_valid, byp_last, byp_ready;
    logic [DW-1:0] byp_data;
    logic [BW-1:0] byp_byteen;
    logic          cache_rdrsp_valid, cache_rdrsp_last, cache_rdrsp_cancel;
    logic [DW-1:0] cache_rdrsp_data;
    logic [BW-1:0] cache_rdrsp_byteen;
    logic          ctrl_rdrsp_ready, err_last_mismatch;

    always #5 clk = ~clk;

    ccp_rdrsp_tx dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_burst_len(cmd_burst_len),
        .cmd_bypass(cmd_bypass), .cmd_cancel(cmd_cancel),
        .arr_valid(arr_valid), .arr_data(arr_data), .arr_ready(arr_ready),
        .byp_valid(byp_valid), .byp_data(byp_data), .byp_byteen(byp_byteen),
        .byp_last(byp_last), .byp_ready(byp_ready),
        .cache_rdrsp_valid(cache_rdrsp_valid), .cache_rdrsp_data(cache_rdrsp_data),
        .cache_rdrsp_byteen(cache_rdrsp_byteen), .cache_rdrsp_last(cache_rdrsp_last),
        .cache_rdrsp_cancel(cache_rdrsp_cancel), .ctrl_rdrsp_ready(ctrl_rdrsp_ready),
        .err_last_mismatch(err_last_mismatch)
    );

    beat_t         exp_q[$];
    cmd_t          cmd_q[$];
    byp_t          byp_q[$];
    logic [DW-1:0] arr_q[$];
    int            hs_cyc_q[$];
    int            tests = 0, fails = 0;
    int            cyc = 0, hs_cnt = 0;
    int            cmd_hs_cyc = -1, first_valid_cyc = -1;
    logic          exp_err = 1'b0;
    logic          stall_prev = 1'b0;
    logic          rand_ready = 1'b0, ready_force = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- sources
    initial begin
        logic hs;
        cmd_valid = 0; cmd_burst_len = '0; cmd_bypass = 0; cmd_cancel = 0;
        forever begin
            @(negedge clk);
            hs = cmd_valid && cmd_ready;
            if (hs) cmd_hs_cyc = cyc;
            @(posedge clk); #1;
            if (hs && cmd_q.size() > 0) void'(cmd_q.pop_front());
            cmd_valid = (cmd_q.size() > 0);
            if (cmd_valid) begin
                cmd_burst_len = cmd_q[0].len;
                cmd_bypass    = cmd_q[0].bypass;
                cmd_cancel    = cmd_q[0].cancel;
            end
        end
    end

    initial begin
        logic hs;
        arr_valid = 0; arr_data = '0;
        forever begin
            @(negedge clk);
            hs = arr_valid && arr_ready;
            @(posedge clk); #1;
            if (hs && arr_q.size() > 0) void'(arr_q.pop_front());
            arr_valid = (arr_q.size() > 0);
            if (arr_valid) arr_data = arr_q[0];
        end
    end

    initial begin
        logic hs;
        byp_valid = 0; byp_data = '0; byp_byteen = '0; byp_last = 0;
        forever begin
            @(negedge clk);
            hs = byp_valid && byp_ready;
            @(posedge clk); #1;
            if (hs && byp_q.size() > 0) void'(byp_q.pop_front());
            byp_valid = (byp_q.size() > 0);
            if (byp_valid) begin
                byp_data   = byp_q[0].data;
                byp_byteen = byp_q[0].be;
                byp_last   = byp_q[0].last;
            end
        end
    end

    initial begin
        ctrl_rdrsp_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            ctrl_rdrsp_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
        end
    end

    // ---------------- monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (stall_prev && exp_q.size() > 0) begin
                check("hold_valid", cache_rdrsp_valid, 1);
                check("hold_data", cache_rdrsp_data, exp_q[0].data);
                check("hold_last", cache_rdrsp_last, exp_q[0].last);
            end
            if (cache_rdrsp_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (cache_rdrsp_valid && ctrl_rdrsp_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    $display("[TB] beat %0d data=%h be=%h last=%b cancel=%b", hs_cnt,
                             cache_rdrsp_data, cache_rdrsp_byteen, cache_rdrsp_last, cache_rdrsp_cancel);
                    check("beat_data", cache_rdrsp_data, e.data);
                    check("beat_byteen", cache_rdrsp_byteen, e.be);
                    check("beat_last", cache_rdrsp_last, e.last);
                    check("beat_cancel", cache_rdrsp_cancel, e.cancel);
                end
                hs_cnt++;
                hs_cyc_q.push_back(cyc);
            end
            stall_prev = cache_rdrsp_valid && !ctrl_rdrsp_ready;
        end else begin
            stall_prev = 1'b0;
        end
    end

    // ---------------- stimulus helpers
    function automatic logic [DW-1:0] rand_word();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic issue_array(input logic [LW-1:0] len);
        beat_t b;
        cmd_t  c;
        for (int i = 0; i <= int'(len); i++) begin
            b.data = rand_word(); b.be = 16'hFFFF; b.last = (i == int'(len)); b.cancel = 0;
            arr_q.push_back(b.data);
            exp_q.push_back(b);
        end
        c.len = len; c.bypass = 0; c.cancel = 0;
        cmd_q.push_back(c);
    endtask

    task automatic push_byp(input logic [BW-1:0] be, input logic lst, input logic exp_last);
        byp_t  p;
        beat_t b;
        p.data = rand_word(); p.be = be; p.last = lst;
        byp_q.push_back(p);
        b.data = p.data; b.be = be; b.last = exp_last; b.cancel = 0;
        exp_q.push_back(b);
        if (lst !== exp_last) exp_err = 1'b1;
    endtask

    task automatic issue_bypass_cmd(input logic [LW-1:0] len);
        cmd_t c;
        c.len = len; c.bypass = 1; c.cancel = 0;
        cmd_q.push_back(c);
    endtask

    task automatic issue_cancel(input logic [LW-1:0] len, input logic byp);
        cmd_t  c;
        beat_t b;
        c.len = len; c.bypass = byp; c.cancel = 1;
        cmd_q.push_back(c);
        b.data = '0; b.be = '0; b.last = 1; b.cancel = 1;
        exp_q.push_back(b);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 2000) check("drain_timeout", DW'(exp_q.size()), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // ---------------- main sequence
    initial begin
        int n, k, sz;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", cache_rdrsp_valid, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_byp_ready", byp_ready, 1);
        check("rst_arr_ready", arr_ready, 0);
        check("rst_err", err_last_mismatch, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk); #1;

        // array burst of 4 with data already waiting
        first_valid_cyc = -1;
        issue_array(2'd3);
        drain();
        check("min_latency", DW'(first_valid_cyc - cmd_hs_cyc), 3);
        check("err_after_array", err_last_mismatch, 0);

        // ready low for 5 cycles mid-burst
        k = hs_cnt;
        issue_array(2'd3);
        n = 0;
        while (hs_cnt < k + 2 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (n >= 200) check("stall_wait_timeout", DW'(hs_cnt - k), 2);
        #1 ready_force = 1'b0;
        repeat (5) @(posedge clk);
        #1 ready_force = 1'b1;
        drain();
        check("stall_beats", DW'(hs_cnt - k), 4);

        // bypass with matching last flags
        issue_bypass_cmd(2'd1);
        push_byp(16'h00FF, 1'b0, 1'b0);
        push_byp(16'hFF00, 1'b1, 1'b1);
        drain();
        check("err_after_bypass", err_last_mismatch, 0);

        // cancel then array len 0: consecutive cycles
        issue_cancel(2'd2, 1'b1);
        issue_array(2'd0);
        drain();
        sz = hs_cyc_q.size();
        check("no_bubble", DW'(hs_cyc_q[sz-1] - hs_cyc_q[sz-2]), 1);

        // random mix with random backpressure
        rand_ready = 1'b1;
        for (int t = 0; t < 12; t++) begin
            logic [LW-1:0] len;
            len = LW'($urandom_range(0, 3));
            case ($urandom_range(0, 2))
                0: issue_array(len);
                1: begin
                    issue_bypass_cmd(len);
                    for (int i = 0; i <= int'(len); i++)
                        push_byp(BW'($urandom()), i == int'(len), i == int'(len));
                end
                default: issue_cancel(len, 1'($urandom_range(0, 1)));
            endcase
        end
        drain();
        rand_ready = 1'b0;
        check("err_after_random", err_last_mismatch, exp_err);

        // bypass last asserted on beat 0: sticky error
        issue_bypass_cmd(2'd1);
        push_byp(16'hF0F0, 1'b1, 1'b0);
        push_byp(16'h0F0F, 1'b1, 1'b1);
        drain();
        check("err_mismatch", err_last_mismatch, exp_err);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("err_sticky", err_last_mismatch, 1);

        // stalled burst, fill command FIFO, then reset mid-burst
        @(posedge clk); #1;
        ready_force = 1'b0;
        begin
            cmd_t  c;
            beat_t b;
            c.len = 2'd3; c.bypass = 0; c.cancel = 0;
            cmd_q.push_back(c);
            b.data = rand_word(); b.be = 16'hFFFF; b.last = 0; b.cancel = 0;
            arr_q.push_back(b.data);
            exp_q.push_back(b);
            c.len = 2'd0;
            for (int i = 0; i < 5; i++) cmd_q.push_back(c);
        end
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("fifo_full_cmd_ready", cmd_ready, 0);
        check("stalled_valid", cache_rdrsp_valid, 1);
        check("stalled_data", cache_rdrsp_data, exp_q[0].data);
        @(posedge clk); #3;
        reset = 1'b1;
        cmd_q.delete();
        arr_q.delete();
        exp_q.delete();
        exp_err = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_valid", cache_rdrsp_valid, 0);
        check("midrst_cmd_ready", cmd_ready, 1);
        check("midrst_byp_ready", byp_ready, 1);
        check("midrst_err", err_last_mismatch, exp_err);
        @(posedge clk); #1;
        reset = 1'b0;
        ready_force = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("post_rst_idle", cache_rdrsp_valid, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
